// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch stage.
// It owns the PC, fetches one instruction at a time over a req/gnt/rvalid
// port, and hands each instruction downstream through a valid/ready port.
// Optional build macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a
// misaligned next PC is loaded unmasked, fetch_misalign is raised, and
// the FSM parks in HALT until reset. When it is undefined, bits [1:0] of
// the next PC are cleared and fetching continues.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    // Memory side: the request is held with a stable address until the
    // memory grants it. The response comes back on rvalid while in WAIT.
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    // Downstream side: valid/ready. Once instr_valid is high, instr and pc
    // stay stable until the cycle in which instr_valid & instr_ready.
    // branch_taken/branch_imm are sampled only in that consume cycle.
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_imm,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        fetch_misalign,
`endif
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
`ifdef FETCH_MISALIGN_TRAP_EN
        S_VALID = 3'd3,
        S_HALT  = 3'd4
`else
        S_VALID = 3'd3
`endif
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        consume;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        misaligned;

    assign consume    = (state == S_VALID) && instr_valid && instr_ready;
    assign target     = branch_taken ? (pc + branch_imm) : (pc + 32'd4);
    assign misaligned = |target[1:0];

`ifdef FETCH_MISALIGN_TRAP_EN
    // The trap build keeps the raw target so software can see the bad address.
    assign next_pc = target;
`else
    // Without the trap, the low two bits are cleared and fetching continues.
    assign next_pc = target & ~32'h0000_0003;
`endif

    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;
    assign dbg_state = state;

    // Next-state logic. Only one request is outstanding at a time.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = S_REQ;
            S_REQ:   if (imem_gnt) state_nx = S_WAIT;
            S_WAIT:  if (imem_rvalid) state_nx = S_VALID;
            S_VALID: begin
                if (consume) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    state_nx = misaligned ? S_HALT : S_REQ;
`else
                    state_nx = S_REQ;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_HALT:  state_nx = S_HALT;
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    // State, PC, instruction capture, and registered valid. Reset takes
    // priority over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_misalign <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            instr_valid <= (state_nx == S_VALID);
            if (state == S_WAIT && imem_rvalid) begin
                instr <= imem_rdata;
            end
            if (consume) begin
                pc <= next_pc;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            if (consume && misaligned) begin
                fetch_misalign <= 1'b1;
            end
`endif
        end
    end

`ifndef FETCH_MISALIGN_TRAP_EN
    // misaligned is only consumed by the trap build.
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with a scoreboard.
// Stimulus tasks drive the memory side and the downstream side. Each fetch
// pushes the expected {pc, instr} pair into exp_q. A separate negedge
// monitor pops one entry per consume handshake and compares it.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_imm;
    logic [2:0]  dbg_state;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_valid_cyc = 0;
    logic [63:0] exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .pc           (pc),
        .instr_ready  (instr_ready),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_misalign (fetch_misalign),
`endif
        .dbg_state    (dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: compare each consumed instruction with the queue
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h expected nothing", pc, instr);
            end else begin
                check("sb_pc_instr", {pc, instr}, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        rst = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        instr_ready = 1'b0;
        branch_taken = 1'b0;
        branch_imm = 32'h0;
        step();
        step();
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_pc_addr", {pc, imem_addr}, 64'h0);
        check("rst_req_valid", 64'({imem_req, instr_valid}), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_misalign", 64'(fetch_misalign), 64'd0);
`endif
        rst = 1'b0;
    endtask

    task automatic fetch_one(input int gd, input int rd, input logic [31:0] data,
                             input logic [31:0] addr);
        int n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        if (!imem_req) begin
            check("req_timeout", 64'd0, 64'd1);
            return;
        end
        check("req_addr", 64'(imem_addr), 64'(addr));
        exp_q.push_back({addr, data});
        for (int i = 0; i < gd; i++) begin
            imem_gnt = 1'b0;
            imem_rvalid = 1'b1;
            imem_rdata = 32'hBAD0_0000;
            step();
            check("req_hold", 64'({imem_req, imem_addr}), 64'({1'b1, addr}));
        end
        imem_rvalid = 1'b0;
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check("wait_entry", 64'({dbg_state, imem_req}), 64'({3'd2, 1'b0}));
        for (int i = 0; i < rd; i++) begin
            step();
            check("wait_noreq", 64'({dbg_state, imem_req, instr_valid}), 64'({3'd2, 2'b00}));
        end
        imem_rvalid = 1'b1;
        imem_rdata = data;
        step();
        imem_rvalid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("valid_up", 64'({instr_valid, dbg_state}), 64'({1'b1, 3'd3}));
        last_valid_cyc = cyc;
    endtask

    task automatic consume(input int rdly, input logic bt, input logic [31:0] imm,
                           input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        int n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        if (!instr_valid) begin
            check("valid_timeout", 64'd0, 64'd1);
            return;
        end
        for (int i = 0; i < rdly; i++) begin
            instr_ready = 1'b0;
            imem_rvalid = 1'b1;
            imem_rdata = 32'hBAD1_1111;
            step();
            check("hold_ctl", 64'({instr_valid, imem_req}), 64'd2);
            check("hold_data", {pc, instr}, {exp_pc, exp_instr});
        end
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        branch_taken = bt;
        branch_imm = imm;
        step();
        instr_ready = 1'b0;
        branch_taken = 1'b0;
        branch_imm = 32'h0;
        check("consumed", 64'(instr_valid), 64'd0);
    endtask

    initial begin
        int c0;
        int prev;
        do_reset();
        c0 = cyc;
        step();
        check("first_req", 64'({dbg_state, imem_req, imem_addr}), 64'({3'd1, 1'b1, 32'h0}));

        // zero-wait sequential fetches: 0x0, 0x4, 0x8 spaced 3 cycles apart
        fetch_one(0, 0, 32'h0000_0013, 32'h0000_0000);
        check("rst_latency", 64'(cyc - c0), 64'd3);
        prev = last_valid_cyc;
        consume(0, 1'b0, 32'h0, 32'h0000_0000, 32'h0000_0013);
        fetch_one(0, 0, 32'h0000_0013, 32'h0000_0004);
        check("seq_spacing1", 64'(last_valid_cyc - prev), 64'd3);
        prev = last_valid_cyc;
        consume(0, 1'b0, 32'h0, 32'h0000_0004, 32'h0000_0013);
        fetch_one(0, 0, 32'h0000_0013, 32'h0000_0008);
        check("seq_spacing2", 64'(last_valid_cyc - prev), 64'd3);
        consume(0, 1'b0, 32'h0, 32'h0000_0008, 32'h0000_0013);

        // stalls on gnt, rvalid and ready
        fetch_one(4, 3, 32'h0050_0093, 32'h0000_000C);
        consume(5, 1'b0, 32'h0, 32'h0000_000C, 32'h0050_0093);

        // branches: 0x10 - 8 -> 0x08, then 0x08 + 0x100 -> 0x108
        fetch_one(0, 0, 32'h00A0_0113, 32'h0000_0010);
        consume(0, 1'b1, 32'hFFFF_FFF8, 32'h0000_0010, 32'h00A0_0113);
        fetch_one(1, 0, 32'h0000_0063, 32'h0000_0008);
        consume(0, 1'b1, 32'h0000_0100, 32'h0000_0008, 32'h0000_0063);
        fetch_one(0, 1, 32'h0001_0137, 32'h0000_0108);
        // 0x108 + 0xFFFF_FEF4 = 0xFFFF_FFFC
        consume(1, 1'b1, 32'hFFFF_FEF4, 32'h0000_0108, 32'h0001_0137);

        // sequential wrap-around 0xFFFF_FFFC + 4 -> 0x0
        fetch_one(0, 0, 32'h0000_006F, 32'hFFFF_FFFC);
        consume(0, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0000_006F);

        // misaligned branch target 0x0 + 6
        fetch_one(0, 0, 32'h0040_0093, 32'h0000_0000);
        consume(0, 1'b1, 32'h0000_0006, 32'h0000_0000, 32'h0040_0093);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("trap_flag_pc", 64'({fetch_misalign, pc}), 64'({1'b1, 32'h0000_0006}));
        check("trap_state", 64'(dbg_state), 64'd4);
        imem_gnt = 1'b1;
        imem_rvalid = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("halt_quiet", 64'({imem_req, instr_valid, fetch_misalign}), 64'd1);
        end
`else
        fetch_one(0, 0, 32'h0000_0013, 32'h0000_0004);
        consume(0, 1'b0, 32'h0, 32'h0000_0004, 32'h0000_0013);
`endif

        // reset in the middle of a WAIT
        do_reset();
        step();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check("mid_wait", 64'(dbg_state), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst", 64'({dbg_state, instr_valid, pc}), 64'({3'd0, 1'b0, 32'h0}));
        step();
        check("refetch_req", 64'({dbg_state, imem_req, imem_addr}), 64'({3'd1, 1'b1, 32'h0}));
        fetch_one(0, 2, 32'h1234_5013, 32'h0000_0000);
        consume(2, 1'b0, 32'h0, 32'h0000_0000, 32'h1234_5013);
        fetch_one(0, 0, 32'h0000_0073, 32'h0000_0004);
        consume(0, 1'b0, 32'h0, 32'h0000_0004, 32'h0000_0073);

        step();
        step();
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of the immediate generator and decoder.
- Owns the PC and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Presents one instruction at a time to downstream logic with a valid/ready handshake.
- Computes the next PC: sequential (PC+4), or branch target using the byte-addressed, sign-extended branch immediate returned by downstream.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first address fetched.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address; equals pc while imem_req=1
imem_gnt  input  1  memory accepts request this cycle (sampled only when imem_req=1)
imem_rvalid  input  1  read data valid (sampled only in WAIT)
imem_rdata  input  32  instruction word
instr_valid  output  1  instr/pc hold a fetched instruction
instr  output  32  fetched instruction, stable while instr_valid=1
pc  output  32  address of instr
instr_ready  input  1  downstream consumes instruction when instr_valid & instr_ready
branch_taken  input  1  sampled on consume; 1 selects branch target
branch_imm  input  32  byte-addressed sign-extended offset, sampled on consume

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, imem_addr=RESET_PC.
  - Reset dominates any event in the same cycle, including mid-handshake.
  - instr_mem shares rst; no rvalid may follow a reset.
- FSM states: IDLE, REQ, WAIT, VALID.
  - IDLE: imem_req=0. Next cycle -> REQ. Occupies exactly one cycle after reset.
  - REQ: imem_req=1, imem_addr=pc.
    - gnt=1 -> WAIT.
    - Otherwise stay in REQ, holding addr stable.
    - rvalid is ignored in REQ.
  - WAIT: imem_req=0.
    - rvalid=1 -> capture imem_rdata into instr, then VALID.
    - Otherwise stay in WAIT (unbounded).
  - VALID: instr_valid=1; instr and pc held stable.
    - instr_ready=0 -> stay in VALID.
    - instr_valid & instr_ready -> update pc, go to REQ, instr_valid=0 next cycle.
    - rvalid in VALID is a protocol error and is ignored.
- Next PC, computed on consume:
  - branch_taken=1: pc + branch_imm.
  - branch_taken=0: pc + 4.
  - All additions are 32-bit modulo 2^32 (0xFFFF_FFFC+4 -> 0x0000_0000; 0x0000_0004+0xFFFF_FFF8 -> 0xFFFF_FFFC).
- Alignment: next PC bits [1:0] are forced to 2'b00 (behaviour without the optional feature).
- Latency, with gnt in the first REQ cycle and rvalid in the first WAIT cycle:
  - Consume -> next instr_valid = 3 cycles.
  - Reset deassert -> first instr_valid = 3 cycles (IDLE, REQ, WAIT).
- At most one outstanding request; no new request is issued before the current instruction is consumed.
- instr_valid is a registered output.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port fetch_misalign (1 bit, reset 0) and a HALT state.
  - If the computed next PC has bit[1] or bit[0] set, pc loads the unmasked target and fetch_misalign=1.
  - FSM enters HALT: imem_req=0, instr_valid=0. Only rst leaves HALT.
- Undefined:
  - No fetch_misalign port and no HALT state.
  - Target bits [1:0] are silently cleared, and fetch proceeds.

Test Plan:
- Reset -> state IDLE, pc=RESET_PC, imem_req=0, instr_valid=0; first imem_req with imem_addr=0x0 one cycle after rst drops.
- Zero-wait memory, instr_ready=1, branch_taken=0, rdata=0x0000_0013 -> pc sequence 0x0, 0x4, 0x8, each instr_valid exactly 3 cycles apart.
- gnt held low 4 cycles, then rvalid delayed 3 cycles, then instr_ready low 5 cycles:
  - imem_addr stable throughout REQ.
  - instr/pc stable throughout VALID.
  - No extra requests issued.
- pc=0x10, consume with branch_taken=1, branch_imm=0xFFFF_FFF8 -> next imem_addr=0x08. Then branch_imm=0x0000_0100 from 0x08 -> 0x108.
- Wrap-around and reset mid-operation:
  - pc=0xFFFF_FFFC, sequential consume -> next imem_addr=0x0000_0000.
  - rst asserted during WAIT -> IDLE, instr_valid=0, refetch from RESET_PC.
- With FETCH_MISALIGN_TRAP_EN, branch_imm=0x0000_0006 from pc=0x0 -> fetch_misalign=1, pc=0x6, imem_req stays 0 until rst. Without the macro -> next imem_addr=0x4.
